// File: rtl/fft_job_sched.sv
// fft_job_sched: round-robin scheduler for two requesters that steps one FFT core through the load, wait, drain and settle phases
module fft_job_sched #(
    parameter int N_BEAT = 64,
    parameter int WDOG   = 255
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [1:0] REQ,
    output logic [1:0] GNT,
    output logic       CORE_START,
    input  logic       CORE_DONE,
    output logic       IN_RDY,
    output logic [5:0] IN_IDX,
    output logic       OUT_VALID,
    output logic [5:0] OUT_IDX,
    output logic [1:0] ACK,
    output logic       ERR,
    output logic       BUSY
);
    typedef enum logic [2:0] {IDLE, ARB, STRT, LOAD, WAIT, DRAIN, SETTLE} state_t;
    localparam logic [6:0] NB    = 7'(N_BEAT);
    localparam logic [6:0] NB_M1 = 7'(N_BEAT - 1);
    localparam logic [7:0] WD    = 8'(WDOG);
    state_t     state_q, state_d;
    logic [1:0] req_q, req_d, gnt_q, gnt_d;
    logic       last_q, last_d, win, full;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] wd_q, wd_d;

    // state register plus latched request, grant, round-robin pointer and counters
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            req_q   <= '0;
            gnt_q   <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    // next-state logic and outputs; cnt_q is the beat counter in LOAD/DRAIN and the stall counter in SETTLE
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        win        = (req_q == 2'b10) | ((req_q == 2'b11) & ~last_q);
        full       = (cnt_q == NB);
        GNT        = gnt_q;
        BUSY       = (state_q != IDLE);
        CORE_START = (state_q == STRT);
        IN_RDY     = (state_q == LOAD);
        IN_IDX     = IN_RDY ? cnt_q[5:0] : '0;
        OUT_VALID  = CORE_DONE & ((state_q == WAIT) | ((state_q == DRAIN) & ~full));
        OUT_IDX    = OUT_VALID ? cnt_q[5:0] : '0;
        ACK        = '0;
        ERR        = 1'b0;
        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    state_d = ARB;
                    req_d   = REQ;
                end
            end
            ARB: begin
                gnt_d   = win ? 2'b10 : 2'b01;
                last_d  = win;
                state_d = STRT;
            end
            STRT: state_d = LOAD;
            LOAD: begin
                cnt_d   = (cnt_q == NB_M1) ? 7'd0 : cnt_q + 7'd1;
                state_d = (cnt_q == NB_M1) ? WAIT : LOAD;
            end
            WAIT: begin
                if (CORE_DONE) begin
                    state_d = DRAIN;
                    cnt_d   = 7'd1;
                    wd_d    = '0;
                end else if (wd_q == WD) begin
                    ERR     = 1'b1;
                    state_d = SETTLE;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            DRAIN: begin
                if (CORE_DONE & ~full) begin
                    cnt_d = cnt_q + 7'd1;
                end else begin
                    ACK     = (~CORE_DONE & full) ? gnt_q : 2'b00;
                    ERR     = CORE_DONE | ~full;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d   = (cnt_q == 7'd2) ? 7'd0 : cnt_q + 7'd1;
                gnt_d   = (cnt_q == 7'd2) ? 2'b00 : gnt_q;
                state_d = (cnt_q == 7'd2) ? IDLE : SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fft_job_sched.sv
// tb_fft_job_sched: directed jobs against a behavioural FFT core, with a scoreboard of expected grant and ACK/ERR outcomes
module tb_fft_job_sched;
    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [1:0] REQ = 2'b00;
    logic [1:0] GNT, ACK;
    logic       CORE_START, CORE_DONE, IN_RDY, OUT_VALID, ERR, BUSY;
    logic [5:0] IN_IDX, OUT_IDX;

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] ack;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   passed = 0, fails = 0, total = 0;
    int   cyc = 0, n_start = 0, n_end = 0, start_cyc = 0, end_cyc = 0, wait_entry = 0;
    int   in_exp = 0, out_exp = 0;
    int   dly = 130, len = 64;
    logic act;
    int   t;

    fft_job_sched #(.N_BEAT(64), .WDOG(255)) dut (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .GNT(GNT), .CORE_START(CORE_START),
        .CORE_DONE(CORE_DONE), .IN_RDY(IN_RDY), .IN_IDX(IN_IDX), .OUT_VALID(OUT_VALID),
        .OUT_IDX(OUT_IDX), .ACK(ACK), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // core model: raises CORE_DONE dly cycles after START for len cycles (len 0 means never)
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            act <= 1'b0;
            t   <= 0;
        end else if (CORE_START) begin
            act <= 1'b1;
            t   <= 1;
        end else if (act) begin
            t <= t + 1;
        end
    end
    assign CORE_DONE = act && t >= dly && t < dly + len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor on the falling edge: beat indices, grants and job outcomes against the scoreboard
    always @(negedge CLK) begin
        cyc++;
        if (RSTn) begin
            if (CORE_START) begin
                n_start++;
                start_cyc = cyc;
                in_exp    = 0;
                out_exp   = 0;
                chk("start_pending", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) chk("gnt_at_start", 32'(GNT), 32'(sb[0].gnt));
            end
            if (IN_RDY) begin
                chk("in_idx", 32'(IN_IDX), in_exp);
                if (IN_IDX == 6'd63) wait_entry = cyc + 1;
                in_exp++;
            end
            if (OUT_VALID) begin
                chk("out_idx", 32'(OUT_IDX), out_exp);
                out_exp++;
            end
            if (ACK != 2'b00 || ERR) begin
                n_end++;
                end_cyc = cyc;
                chk("ack_err_excl", 32'(ACK != 2'b00 && ERR), 0);
                chk("end_pending", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    chk("gnt_at_end", 32'(GNT), 32'(sb[0].gnt));
                    chk("ack", 32'(ACK), 32'(sb[0].ack));
                    chk("err", 32'(ERR), 32'(sb[0].err));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (BUSY && k < 2000) begin
            step();
            k++;
        end
        chk({tag, "_idle"}, 32'(BUSY), 0);
    endtask

    task automatic run_job(input logic [1:0] r, input exp_t e, input string tag);
        int s0 = n_start, e0 = n_end, k = 0;
        sb.push_back(e);
        REQ = r;
        while (n_start == s0 && k < 100) begin
            step();
            k++;
        end
        REQ = 2'b00;
        k = 0;
        while (n_end == e0 && k < 1000) begin
            step();
            k++;
        end
        chk({tag, "_done"}, n_end - e0, 1);
    endtask

    initial begin
        int   s0, e0, k;
        logic ov;
        step();
        chk("reset_outputs", 32'({GNT, CORE_START, IN_RDY, IN_IDX, OUT_VALID, OUT_IDX, ACK, ERR, BUSY}), 0);
        RSTn = 1'b1;
        step();
        step();
        chk("idle_outputs", 32'({GNT, CORE_START, IN_RDY, IN_IDX, OUT_VALID, OUT_IDX, ACK, ERR, BUSY}), 0);

        // both requesting for three jobs: requester 0 wins the first tie, then alternation
        s0 = n_start;
        sb.push_back('{2'b01, 2'b01, 1'b0});
        sb.push_back('{2'b10, 2'b10, 1'b0});
        sb.push_back('{2'b01, 2'b01, 1'b0});
        REQ = 2'b11;
        k = 0;
        while (n_start < s0 + 3 && k < 2000) begin
            step();
            k++;
        end
        REQ = 2'b00;
        chk("tie_starts", n_start - s0, 3);
        k = 0;
        while (sb.size() > 0 && k < 1000) begin
            step();
            k++;
        end
        wait_idle("tie");
        chk("tie_sb_empty", sb.size(), 0);

        // single clean job: one START, 64 load and drain beats, ACK when CORE_DONE falls
        s0 = n_start;
        run_job(2'b01, '{2'b01, 2'b01, 1'b0}, "single");
        wait_idle("single");
        chk("single_one_start", n_start - s0, 1);
        chk("single_in_beats", in_exp, 64);
        chk("single_out_beats", out_exp, 64);
        chk("single_ack_time", end_cyc - start_cyc, dly + len);
        chk("single_gnt_drop", 32'(GNT), 0);

        // requester 0 drops and requester 1 rises during LOAD: job 0 still ACKed, job 1 served afterwards
        s0 = n_start;
        sb.push_back('{2'b01, 2'b01, 1'b0});
        REQ = 2'b01;
        k = 0;
        while (!(IN_RDY && IN_IDX == 6'd10) && k < 200) begin
            step();
            k++;
        end
        chk("midjob_reach_load", 32'(IN_IDX), 10);
        REQ = 2'b10;
        sb.push_back('{2'b10, 2'b10, 1'b0});
        k = 0;
        while (n_start < s0 + 2 && k < 1000) begin
            step();
            k++;
        end
        REQ = 2'b00;
        chk("midjob_starts", n_start - s0, 2);
        k = 0;
        while (sb.size() > 0 && k < 1000) begin
            step();
            k++;
        end
        wait_idle("midjob");
        chk("midjob_sb_empty", sb.size(), 0);

        // core never answers: watchdog abort 255 cycles into WAIT
        len = 0;
        run_job(2'b10, '{2'b10, 2'b00, 1'b1}, "wdog");
        chk("wdog_time", end_cyc - wait_entry, 255);
        wait_idle("wdog");
        chk("wdog_gnt_drop", 32'(GNT), 0);

        // short output burst: ERR when CORE_DONE falls after 40 beats
        len = 40;
        run_job(2'b01, '{2'b01, 2'b00, 1'b1}, "short");
        chk("short_beats", out_exp, 40);
        chk("short_err_time", end_cyc - start_cyc, dly + 40);
        wait_idle("short");

        // long output burst: ERR on beat 65 and OUT_VALID held low afterwards
        len = 70;
        run_job(2'b01, '{2'b01, 2'b00, 1'b1}, "long");
        chk("long_err_time", end_cyc - start_cyc, dly + 64);
        ov = 1'b0;
        repeat (8) begin
            step();
            ov |= OUT_VALID;
        end
        chk("long_valid_low", 32'(ov), 0);
        chk("long_beats", out_exp, 64);
        wait_idle("long");
        len = 64;

        // reset during LOAD beat 20: outputs clear at once, no outcome, fresh job afterwards
        e0 = n_end;
        sb.push_back('{2'b01, 2'b01, 1'b0});
        REQ = 2'b01;
        k = 0;
        while (!(IN_RDY && IN_IDX == 6'd20) && k < 200) begin
            step();
            k++;
        end
        chk("rst_reach_beat20", 32'(IN_IDX), 20);
        REQ = 2'b00;
        RSTn = 1'b0;
        #1;
        chk("rst_outputs", 32'({GNT, CORE_START, IN_RDY, IN_IDX, OUT_VALID, OUT_IDX, ACK, ERR, BUSY}), 0);
        if (sb.size() > 0) void'(sb.pop_front());
        step();
        step();
        chk("rst_no_outcome", n_end - e0, 0);
        RSTn = 1'b1;
        s0 = n_start;
        run_job(2'b10, '{2'b10, 2'b10, 1'b0}, "post_rst");
        wait_idle("post_rst");
        chk("post_rst_in_beats", in_exp, 64);
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fft_job_sched.md
FFT_JOB_SCHED -- requirements
Module: fft_job_sched

Interface
REQ-001 Parameter N_BEAT, default 64, SHALL set the beats per load and per drain phase (core transform length / 4 lanes).
REQ-002 Parameter WDOG, default 255, SHALL set the maximum cycles spent in WAIT before an abort.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port RSTn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port REQ  input  2  SHALL be per-requester job request levels, sampled only in IDLE.
REQ-006 Port GNT  output  2  SHALL be the one-hot grant, held from ARB exit until SETTLE exit.
REQ-007 Port CORE_START  output  1  SHALL be a one-cycle start pulse to the FFT core.
REQ-008 Port CORE_DONE  input  1  SHALL be the core output-phase indicator, high for N_BEAT cycles.
REQ-009 Port IN_RDY  output  1  SHALL mark the load window in which the granted requester drives samples.
REQ-010 Port IN_IDX  output  6  SHALL be the load beat index.
REQ-011 Port OUT_VALID  output  1  SHALL mark valid core output beats for the granted requester.
REQ-012 Port OUT_IDX  output  6  SHALL be the drain beat index.
REQ-013 Port ACK  output  2  SHALL pulse for one cycle on the granted requester's bit when its job completes.
REQ-014 Port ERR  output  1  SHALL pulse for one cycle when a job aborts.
REQ-015 Port BUSY  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 States: IDLE, ARB, STRT, LOAD, WAIT, DRAIN, SETTLE.
REQ-017 IDLE -> ARB when |REQ is 1; otherwise stay in IDLE.
REQ-018 ARB: round-robin on pointer LAST. Single request wins. When both request, the index != LAST wins. LAST updates to the winner. Next state is STRT (1 cycle).
REQ-019 STRT: CORE_START = 1 for exactly this cycle. Next state is LOAD.
REQ-020 LOAD: lasts N_BEAT cycles. IN_RDY = 1. IN_IDX runs 0..N_BEAT-1, incrementing by 1 per cycle. After beat N_BEAT-1, go to WAIT.
REQ-021 The first LOAD cycle SHALL coincide with the core's first input cycle, so the core input count equals IN_IDX.
REQ-022 WAIT: a watchdog counts from 0.
- CORE_DONE = 1 -> DRAIN, counter cleared.
- Counter reaches WDOG with CORE_DONE = 0 -> ERR pulse, go to SETTLE.
REQ-023 DRAIN: OUT_VALID = CORE_DONE. OUT_IDX increments on each cycle with CORE_DONE = 1, starting at 0.
- Entering DRAIN from WAIT counts that CORE_DONE cycle as beat 0.
REQ-024 DRAIN exit on CORE_DONE falling:
- If exactly N_BEAT beats were counted -> ACK[granted] pulse, go to SETTLE.
- Otherwise -> ERR pulse, no ACK, go to SETTLE.
REQ-025 DRAIN: if CORE_DONE stays high beyond N_BEAT beats -> ERR pulse on beat N_BEAT+1, go to SETTLE, and OUT_VALID is forced to 0.
REQ-026 SETTLE: lasts 3 cycles, matching the core's post-output stall. Then IDLE, and GNT drops.
REQ-027 ACK and ERR SHALL never be asserted in the same cycle. Each job ends with exactly one of them.
REQ-028 A requester dropping REQ after ARB SHALL NOT affect the running job.
REQ-029 REQ asserted mid-job SHALL be served only after returning to IDLE.
REQ-030 IN_IDX and OUT_IDX SHALL read 0 outside LOAD and DRAIN respectively.
REQ-031 IN_IDX and OUT_IDX SHALL NOT wrap within a phase.
REQ-032 The watchdog counter SHALL be 8 bits wide and SHALL saturate at WDOG.
REQ-033 CORE_DONE in any state other than WAIT or DRAIN SHALL be ignored.
REQ-034 Idle-to-idle latency of a clean job SHALL be N_BEAT + core latency + N_BEAT + 5 cycles (ARB, STRT, 3x SETTLE).

Reset
REQ-035 While RSTn = 0: state IDLE, LAST = 1 (requester 0 wins the first tie), all counters 0.
REQ-036 While RSTn = 0, all outputs SHALL be 0.
REQ-037 Reset asserted mid-job SHALL abort immediately, with no ACK or ERR pulse. Operation resumes from IDLE on the first clock edge after release.

Verification
REQ-038 REQ = 2'b01 once, core model asserts CORE_DONE 130 cycles after START for 64 cycles -> GNT = 01, one CORE_START, IN_IDX 0..63, OUT_IDX 0..63, ACK = 01 once, ERR never.
REQ-039 REQ = 2'b11 held for three jobs -> grant order 01, 10, 01, each job ACKed on the matching bit.
REQ-040 CORE_DONE never asserted -> ERR pulse exactly 255 cycles after WAIT entry, then SETTLE, IDLE, GNT = 00, no ACK.
REQ-041 CORE_DONE high for only 40 cycles -> ERR on the falling edge, no ACK. CORE_DONE high for 70 cycles -> ERR on beat 65, OUT_VALID low afterwards.
REQ-042 RSTn pulsed low at LOAD beat 20 -> all outputs 0 immediately. After release with REQ = 2'b10, a fresh job starts with IN_IDX from 0.
REQ-043 REQ[0] dropped during LOAD -> job completes normally and ACK = 01 is still issued.
